// File: rtl/alu_pkg.sv
// seq_alu shared definitions
// op codes, FSM states, overflow helper
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // sa/sb: operand signs, sr: result sign
  function automatic logic ovf_flag(
    input logic is_sub,
    input logic sa,
    input logic sb,
    input logic sr
  );
    if (is_sub)
      return (sa != sb) && (sr != sa);
    else
      return (sa == sb) && (sr != sa);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier
// product/done are valid combinationally on the last step
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               busy;

  // one shift-add step on the current multiplier LSB
  always_comb begin
    acc_nxt = acc;
    if (mplier[0])
      acc_nxt = acc + mcand;
  end

  assign done    = busy && (cnt == CNT_W'(WIDTH - 1));
  assign product = acc_nxt;

  // load on start, then step once per edge until last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (done)
        busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshake
// single-cycle logic ops, iterative multiply
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               flag_z,
  output logic               flag_c,
  output logic               flag_v
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             state;
  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     dif;
  logic [2*WIDTH-1:0] alu_res;
  logic               alu_c;
  logic               alu_v;

  assign accept    = in_valid && in_ready && (state == IDLE);
  assign mul_start = accept && (op == OP_MUL);

  alu_mul_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .product (mul_prod),
    .done    (mul_done)
  );

  // single-cycle result and flags for ops other than MUL
  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    dif     = {1'b0, a} - {1'b0, b};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = {{(WIDTH-1){1'b0}}, sum};
        alu_c   = sum[WIDTH];
        alu_v   = ovf_flag(1'b0, a[WIDTH-1],
                           b[WIDTH-1], sum[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = {{WIDTH{1'b0}}, dif[WIDTH-1:0]};
        alu_c   = dif[WIDTH];
        alu_v   = ovf_flag(1'b1, a[WIDTH-1],
                           b[WIDTH-1], dif[WIDTH-1]);
      end
      OP_AND: alu_res = {{WIDTH{1'b0}}, a & b};
      OP_OR:  alu_res = {{WIDTH{1'b0}}, a | b};
      OP_XOR: alu_res = {{WIDTH{1'b0}}, a ^ b};
      OP_NOT: alu_res = {{WIDTH{1'b0}}, ~a};
      OP_SLT: alu_res = {{(2*WIDTH-1){1'b0}},
                         $signed(a) < $signed(b)};
      default: alu_res = '0;
    endcase
  end

  // handshake FSM with registered result and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (op == OP_MUL) begin
              state <= MUL;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= alu_res;
              flag_z    <= (alu_res == '0);
              flag_c    <= alu_c;
              flag_v    <= alu_v;
            end
          end
        end
        MUL: begin
          if (mul_done) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= mul_prod;
            flag_z    <= (mul_prod == '0);
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=4)
// transaction-level reference model plus directed literals
module tb_seq_alu;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [2*W-1:0] result;
  logic         flag_z;
  logic         flag_c;
  logic         flag_v;

  int n_cmp = 0;
  int n_bad = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // golden answer as {v, c, z, result[7:0]}
  function automatic logic [10:0] golden(
    input logic [2:0] o,
    input logic [3:0] x,
    input logic [3:0] y
  );
    int ux, uy, sx, sy, r;
    logic c, v;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= 8) ? ux - 16 : ux;
    sy = (uy >= 8) ? uy - 16 : uy;
    r = 0;
    c = 1'b0;
    v = 1'b0;
    case (o)
      3'd0: begin
        r = ux + uy;
        c = (r > 15);
        v = (sx + sy > 7) || (sx + sy < -8);
      end
      3'd1: begin
        r = (ux - uy) & 15;
        c = (ux < uy);
        v = (sx - sy > 7) || (sx - sy < -8);
      end
      3'd2: r = ux & uy;
      3'd3: r = ux | uy;
      3'd4: r = ux ^ uy;
      3'd5: r = (~ux) & 15;
      3'd6: r = (sx < sy) ? 1 : 0;
      default: r = ux * uy;
    endcase
    return {v, c, (r == 0), 8'(r)};
  endfunction

  // model: pending result countdown and held result
  logic       m_have = 1'b0;
  int         m_wait = 0;
  logic [7:0] m_res = '0;
  logic       m_z = 1'b0;
  logic       m_c = 1'b0;
  logic       m_v = 1'b0;
  logic [10:0] m_pend = '0;
  logic [10:0] g;

  always_comb g = golden(op, a, b);

  // model advance per clock
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_have <= 1'b0;
      m_wait <= 0;
      m_res  <= '0;
      m_z    <= 1'b0;
      m_c    <= 1'b0;
      m_v    <= 1'b0;
    end else if (m_have) begin
      if (out_ready)
        m_have <= 1'b0;
    end else if (m_wait > 0) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) begin
        m_have <= 1'b1;
        {m_v, m_c, m_z, m_res} <= m_pend;
      end
    end else if (in_valid) begin
      if (op == 3'd7) begin
        m_pend <= g;
        m_wait <= W;
      end else begin
        m_have <= 1'b1;
        {m_v, m_c, m_z, m_res} <= g;
      end
    end
  end

  // per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready", 32'(in_ready),
          32'(!m_have && m_wait == 0));
      chk("out_valid", 32'(out_valid), 32'(m_have));
      chk("result", 32'(result), 32'(m_res));
      chk("flag_z", 32'(flag_z), 32'(m_z));
      chk("flag_c", 32'(flag_c), 32'(m_c));
      chk("flag_v", 32'(flag_v), 32'(m_v));
    end
  end

  logic [7:0] r;
  logic       rz, rc, rv;
  int         lat;

  task automatic run_op(input logic [2:0] o,
                        input logic [3:0] x,
                        input logic [3:0] y,
                        input int hold);
    int gd;
    logic rdy;
    gd = 0;
    out_ready = 1'b0;
    while (!in_ready && gd < 20) begin
      @(posedge clk); #2;
      gd++;
    end
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #2;
    lat = 1;
    rdy = in_ready;
    while (!out_valid && lat < 20) begin
      in_valid = 1'($urandom);
      op = 3'($urandom);
      a = 4'($urandom);
      b = 4'($urandom);
      @(posedge clk); #2;
      lat++;
      rdy |= in_ready;
    end
    chk("out_valid_seen", 32'(out_valid), 32'd1);
    chk("busy_ready", 32'(rdy), 32'd0);
    r = result; rz = flag_z; rc = flag_c; rv = flag_v;
    repeat (hold) begin
      in_valid = 1'($urandom);
      a = 4'($urandom);
      @(posedge clk); #2;
      chk("hold_result", 32'(result), 32'(r));
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
    chk("ready_after", 32'(in_ready), 32'd1);
    chk("valid_after", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #2;

    run_op(3'd0, 4'd3, 4'd4, 0);
    chk("add34_res", 32'(r), 32'h07);
    chk("add34_c", 32'(rc), 32'd0);
    chk("add34_v", 32'(rv), 32'd0);
    chk("add34_z", 32'(rz), 32'd0);
    chk("add34_lat", 32'(lat), 32'd1);

    run_op(3'd0, 4'd15, 4'd1, 0);
    chk("add151_res", 32'(r), 32'h10);
    chk("add151_c", 32'(rc), 32'd1);
    chk("add151_z", 32'(rz), 32'd0);

    run_op(3'd0, 4'd7, 4'd1, 0);
    chk("add71_res", 32'(r), 32'h08);
    chk("add71_v", 32'(rv), 32'd1);
    chk("add71_c", 32'(rc), 32'd0);

    run_op(3'd1, 4'd3, 4'd4, 0);
    chk("sub34_res", 32'(r), 32'h0F);
    chk("sub34_c", 32'(rc), 32'd1);
    chk("sub34_v", 32'(rv), 32'd0);

    run_op(3'd1, 4'd4, 4'd4, 0);
    chk("sub44_res", 32'(r), 32'h00);
    chk("sub44_z", 32'(rz), 32'd1);

    run_op(3'd6, 4'hF, 4'd1, 0);
    chk("slt_res", 32'(r), 32'h01);

    run_op(3'd7, 4'd15, 4'd15, 0);
    chk("mul_res", 32'(r), 32'hE1);
    chk("mul_lat", 32'(lat), 32'd5);

    run_op(3'd7, 4'd0, 4'd9, 0);
    chk("mul0_res", 32'(r), 32'h00);
    chk("mul0_z", 32'(rz), 32'd1);

    run_op(3'd2, 4'hC, 4'hA, 3);
    chk("and_res", 32'(r), 32'h08);
    run_op(3'd4, 4'h5, 4'h3, 0);
    chk("next_accept_lat", 32'(lat), 32'd1);
    chk("xor_res", 32'(r), 32'h06);

    op = 3'd7; a = 4'd5; b = 4'd6; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0; a = 4'd9; b = 4'd9;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("mid_mul_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_flags", 32'({flag_z, flag_c, flag_v}), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    run_op(3'd0, 4'd3, 4'd4, 0);
    chk("post_rst_add", 32'(r), 32'h07);

    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      op        = 3'($urandom_range(0, 7));
      a         = 4'($urandom_range(0, 15));
      b         = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 99) < 70);
      rst_n     = (i != 300);
      @(posedge clk); #2;
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
